alu16_sequencer: RTL

Multi-cycle initiator that executes 16-bit operations on the core's 8-bit ALU by issuing two chained byte operations. The low and high bytes are ordered so that the ALU's internal carry propagates between them. The block sits between the CPU control unit and the 8-bit ALU, and drives the ALU's operator, operand and latch inputs. It returns a 16-bit result and {C,V,Z,N} flags to the core with a start/done handshake.

---
 rtl/alu16_sequencer_if.sv | 71 +++++++
 rtl/alu16_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu16_sequencer_if.sv
// Operation codes and the bundled core/ALU connection of alu16_sequencer.
//
// alu16_pkg : shared CPU op encoding. The code space is split by the
//             'single' bit: two-operand ops (single=0) and single-operand
//             ops (single=1) reuse the same 4-bit operator values.
// alu16_sequencer_if : every signal between the core, the sequencer and the
//             8-bit ALU except clk/rst_n.
//   core side : start, single, operator, a, b -> busy, done, result, flags, err
//   ALU side  : alu_latch, alu_single, alu_operator, alu_value1, alu_value2
//               -> alu_result, alu_flags
//   modport slave  : the sequencer
//   modport master : whatever drives the requests and hosts the ALU
//
// Handshake: start is sampled only while the sequencer is idle; the cycle it
// is seen high there is the accept. busy is high from the cycle after accept
// until done. done is a one-cycle pulse; result/flags/err are valid from that
// cycle and hold until the next accept. A start raised in the done cycle is
// not taken; it has to be presented again once the sequencer is idle.
package alu16_pkg;
  // two-operand ops, single = 0
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  // single-operand ops, single = 1
  localparam logic [3:0] OP_COM = 4'h0;
  localparam logic [3:0] OP_NEG = 4'h1;
  localparam logic [3:0] OP_LSL = 4'h2;
  localparam logic [3:0] OP_LSR = 4'h3;
  localparam logic [3:0] OP_ROL = 4'h4;
  localparam logic [3:0] OP_ROR = 4'h5;
  localparam logic [3:0] OP_RLC = 4'h6;
  localparam logic [3:0] OP_RRC = 4'h7;
endpackage

interface alu16_sequencer_if;
  logic        start;
  logic        single;
  logic [3:0]  operator;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        err;
  logic        alu_latch;
  logic        alu_single;
  logic [3:0]  alu_operator;
  logic [7:0]  alu_value1;
  logic [7:0]  alu_value2;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;

  modport master (
    output start, single, operator, a, b, alu_result, alu_flags,
    input  busy, done, result, flags, err,
           alu_latch, alu_single, alu_operator, alu_value1, alu_value2
  );

  modport slave (
    input  start, single, operator, a, b, alu_result, alu_flags,
    output busy, done, result, flags, err,
           alu_latch, alu_single, alu_operator, alu_value1, alu_value2
  );
endinterface

// File: rtl/alu16_sequencer.sv
// Runs a 16-bit operation on the core's 8-bit ALU as two chained byte ops.
// The ALU keeps its carry internally between latches, so the byte order is
// chosen so that carry flows the right way: low byte first for add/sub and
// left shifts, high byte first for right shifts.
//
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   bus          : alu16_sequencer_if.slave (core request/response + ALU drive)
//   dbg_state_o  : current FSM state, for observation only
//
// Parameter SETTLE_CYCLES (1..15): cycles the ALU inputs are held stable
// before each latch pulse.
module alu16_sequencer
  import alu16_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu16_sequencer_if.slave  bus,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE, SETUP1, LATCH1, CAPT1, SETUP2, LATCH2, CAPT2, DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  // decode of the incoming request
  logic        dec_ok, dec_hi_first;
  logic [3:0]  dec_op_lo, dec_op_hi;

  // captured request
  logic [15:0] a_q, b_q;
  logic [3:0]  op_lo_q, op_hi_q;
  logic        hi_first_q;
  logic [7:0]  byte1_q;   // result byte of the first byte op
  logic        v_hi_q;    // overflow of the first op, used when it was the high byte

  // registered outputs
  logic        busy_q, done_q, err_q, latch_q;
  logic [15:0] result_q;
  logic [3:0]  flags_q;
  logic        alu_single_q;
  logic [3:0]  alu_op_q;
  logic [7:0]  alu_v1_q, alu_v2_q;

  logic [15:0] res16;
  logic        v16;
  logic        unused_alu_zn;

  // The ALU's Z and N describe one byte only; both are rebuilt from the
  // full 16-bit result instead.
  assign unused_alu_zn = ^bus.alu_flags[1:0];

  // Byte sequencing table: which op goes to each byte and which byte first.
  always_comb begin
    dec_ok       = 1'b1;
    dec_hi_first = 1'b0;
    dec_op_lo    = bus.operator;
    dec_op_hi    = bus.operator;
    if (!bus.single) begin
      case (bus.operator)
        OP_ADD: dec_op_hi = OP_ADC;
        OP_SUB: dec_op_hi = OP_SBC;
        OP_CMP: begin
          dec_op_lo = OP_SUB;
          dec_op_hi = OP_SBC;
        end
        OP_ADC, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_MOV: ;
        default: dec_ok = 1'b0;
      endcase
    end else begin
      case (bus.operator)
        OP_LSL: dec_op_hi = OP_RLC;
        OP_LSR: begin
          dec_op_lo    = OP_RRC;
          dec_hi_first = 1'b1;
        end
        OP_RRC: dec_hi_first = 1'b1;
        OP_COM, OP_RLC: ;
        default: dec_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = dec_ok ? SETUP1 : DONE;
        end
      end
      SETUP1: begin
        if (cnt_q == SETTLE_LAST) state_d = LATCH1;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      LATCH1: state_d = CAPT1;
      CAPT1:  state_d = SETUP2;
      SETUP2: begin
        if (cnt_q == SETTLE_LAST) state_d = LATCH2;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      LATCH2: state_d = CAPT2;
      CAPT2:  state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final result assembled in CAPT2 from the stored first byte and the
  // ALU's current output; V always comes from the high-byte op.
  always_comb begin
    res16 = hi_first_q ? {byte1_q, bus.alu_result} : {bus.alu_result, byte1_q};
    v16   = hi_first_q ? v_hi_q : bus.alu_flags[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      op_lo_q      <= 4'd0;
      op_hi_q      <= 4'd0;
      hi_first_q   <= 1'b0;
      byte1_q      <= 8'd0;
      v_hi_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      latch_q      <= 1'b0;
      result_q     <= 16'd0;
      flags_q      <= 4'd0;
      alu_single_q <= 1'b0;
      alu_op_q     <= 4'd0;
      alu_v1_q     <= 8'd0;
      alu_v2_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= (state_d == LATCH1) || (state_d == LATCH2);
      busy_q  <= (state_d != IDLE) && (state_d != DONE);
      done_q  <= (state_d == DONE);

      if (accept) begin
        a_q        <= bus.a;
        b_q        <= bus.single ? 16'd0 : bus.b;
        op_lo_q    <= dec_op_lo;
        op_hi_q    <= dec_op_hi;
        hi_first_q <= dec_hi_first;
        err_q      <= !dec_ok;
        if (dec_ok) begin
          alu_single_q <= bus.single;
          alu_op_q     <= dec_hi_first ? dec_op_hi : dec_op_lo;
          alu_v1_q     <= dec_hi_first ? bus.a[15:8] : bus.a[7:0];
          alu_v2_q     <= bus.single ? 8'd0
                                     : (dec_hi_first ? bus.b[15:8] : bus.b[7:0]);
        end else begin
          result_q <= 16'd0;
          flags_q  <= 4'd0;
        end
      end

      // Keep the first byte and switch the ALU inputs to the other byte.
      if (state_q == CAPT1) begin
        byte1_q  <= bus.alu_result;
        v_hi_q   <= bus.alu_flags[2];
        alu_op_q <= hi_first_q ? op_lo_q : op_hi_q;
        alu_v1_q <= hi_first_q ? a_q[7:0] : a_q[15:8];
        alu_v2_q <= hi_first_q ? b_q[7:0] : b_q[15:8];
      end

      if (state_q == CAPT2) begin
        result_q <= res16;
        flags_q  <= {bus.alu_flags[3], v16, (res16 == 16'd0), res16[15]};
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.result       = result_q;
  assign bus.flags        = flags_q;
  assign bus.alu_latch    = latch_q;
  assign bus.alu_single   = alu_single_q;
  assign bus.alu_operator = alu_op_q;
  assign bus.alu_value1   = alu_v1_q;
  assign bus.alu_value2   = alu_v2_q;
  assign dbg_state_o      = state_q;

endmodule
